uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
// - UART receiver; mirror of the Tx serializer path. Oversamples RX_IN at Prescale clocks/bit.
// - Majority-votes three mid-bit samples. Frame: start(0), DATA_WIDTH bits LSB first,
//   optional parity, stop(1).
// - Delivers P_DATA with a 1-cycle data_valid to the sync/register-file side; flags parity/stop errors.
// PARAMETERS
// - DATA_WIDTH  (parameters_pkg, 8)  payload bits per frame
// - PRESCALE_W  6                    width of Prescale input; legal Prescale values 8, 16, 32
// PORTS
// - CLK         in   1           single receive clock (oversampling clock)
// - RST         in   1           asynchronous, active-low reset
// - RX_IN       in   1           serial line, idle high, already synchronised
// - Prescale    in   PRESCALE_W  oversampling ratio
// - PAR_EN      in   1           1 = parity bit present
// - PAR_TYP     in   1           0 = even, 1 = odd
// - P_DATA      out  DATA_WIDTH  last good received word
// - data_valid  out  1           1-cycle pulse, P_DATA updated this cycle
// - par_err     out  1           1-cycle pulse, parity mismatch
// - stp_err     out  1           1-cycle pulse, stop bit sampled 0
// BEHAVIOUR
// - Reset: state IDLE, edge_cnt=0, bit_cnt=0; outputs P_DATA=0, data_valid=0, par_err=0, stp_err=0.
// - Configuration latch:
//   - Prescale, PAR_EN and PAR_TYP are latched in the start-detect cycle.
//   - Changes mid-frame are ignored.
// - edge_cnt: counts 0..Prescale-1 per bit, wraps to 0; the start-detect cycle is edge 0.
// - Sampling:
//   - Samples taken at edges Prescale/2-1, Prescale/2 and Prescale/2+1.
//   - bit = majority(3), registered at edge Prescale/2+2.
// - FSM:
//   - IDLE: RX_IN==0 -> START.
//   - START: at edge Prescale-1, sampled==1 (glitch) -> IDLE, no flags; else -> DATA.
//   - DATA: shift bit in at MSB (LSB-first line order).
//     - After bit DATA_WIDTH-1 completes -> PARITY if PAR_EN, else -> STOP.
//   - PARITY: expected = ^data ^ PAR_TYP. Mismatch is stored in a sticky par_fail register.
//   - STOP: at edge Prescale-1 -> IDLE. In the same cycle:
//     - sampled==0              -> stp_err=1
//     - par_fail                -> par_err=1
//     - both clear              -> P_DATA<=shift reg, data_valid=1
//     - Both errors can pulse together.
// - Error frames: data_valid stays 0 and P_DATA keeps its previous value.
// - Latency: with frame bits F = 2+DATA_WIDTH+PAR_EN, outputs pulse at cycle F*Prescale-1,
//   counting the start-detect cycle as 0.
// - Back-to-back frames: IDLE is re-entered the cycle after STOP ends; a low line there starts
//   the next frame.
// - Break (line held low): every frame ends in stp_err, then immediately restarts.
// - Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.
// - Arithmetic:
//   - edge_cnt is PRESCALE_W bits; bit_cnt is $clog2(DATA_WIDTH) bits.
//   - Prescale/2 is computed by shift; no wider intermediates.
// STRUCTURE
// - parameters_pkg: add typedef enum logic [2:0] {RX_IDLE,RX_START,RX_DATA,RX_PARITY,RX_STOP} rx_state_e.
//   DATA_WIDTH already lives there.
// - Sub-module uart_rx_data_sampler:
//   - Contains the edge counter, 3-sample majority vote and sample_valid strobe.
//   - uart_rx_core holds the FSM, shift register, parity and output registers.
// TESTING
// - Prescale=8, DATA_WIDTH=8, PAR_EN=1, PAR_TYP=0, send 0xA5 with parity 0
//   -> data_valid at cycle 87, P_DATA=0xA5, no errors.
// - Same frame with parity bit 1
//   -> par_err pulse at cycle 87, data_valid 0, P_DATA stays 0xA5.
// - PAR_EN=0, Prescale=16, send 0x3C with stop bit 0
//   -> stp_err at cycle 159, no valid.
// - Back-to-back 0x3C then 0xC3 (PAR_EN=0, Prescale=16)
//   -> two valid pulses 160 cycles apart, P_DATA 0x3C then 0xC3.
// - RX_IN low 3 cycles then high (Prescale=8)
//   -> START aborted at edge 7, no output pulses, FSM in IDLE.
// - 1-cycle glitch on edge Prescale/2 inside a data bit -> bit still decoded correctly.
// - RST asserted mid-DATA, then a clean 0x5A frame -> only 0x5A reported.

Source files
------------

// File: rtl/parameters_pkg.sv
// ---------------------------------------------------------------------------
// parameters_pkg
// Shared constants and types for the UART receive path.
//   DATA_WIDTH  payload bits per frame
//   PRESCALE_W  width of the oversampling-ratio input
//   rx_state_e  receiver FSM states
//   majority3   2-of-3 vote used on the mid-bit samples
// ---------------------------------------------------------------------------
package parameters_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int PRESCALE_W = 6;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_data_sampler
// Per-bit edge counter and 3-sample majority voter for the UART receiver.
// Ports:
//   clk, rst_n    oversampling clock, asynchronous active-low reset
//   run           count this cycle (frame in progress or start detected)
//   prescale      latched oversampling ratio (8, 16 or 32)
//   rx_in         serial line, already synchronised
//   sampled_bit   majority of the three mid-bit samples of the current bit
//   sample_valid  high on the last edge of a bit period (edge prescale-1)
// ---------------------------------------------------------------------------
module uart_rx_data_sampler #(
   parameter int PRESCALE_W = parameters_pkg::PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  rx_in,
   output logic                  sampled_bit,
   output logic                  sample_valid
);
   import parameters_pkg::*;

   logic [PRESCALE_W-1:0] edge_cnt_reg;
   logic [PRESCALE_W-1:0] edge_cnt_next;
   logic [PRESCALE_W-1:0] half_edge;
   logic [PRESCALE_W-1:0] last_edge;
   logic [PRESCALE_W-1:0] vote_edge;
   logic [2:0]            taps;
   logic                  sampled_bit_reg;

   assign half_edge = prescale >> 1;
   assign last_edge = prescale - PRESCALE_W'(1);
   // Vote is taken one edge after the last tap has been captured.
   assign vote_edge = half_edge + PRESCALE_W'(2);

   // Counter sits at 0 while idle so the start-detect cycle is edge 0.
   always_comb begin
      edge_cnt_next = '0;
      if (run && (edge_cnt_reg != last_edge)) begin
         edge_cnt_next = edge_cnt_reg + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt_reg <= '0;
      end else begin
         edge_cnt_reg <= edge_cnt_next;
      end
   end

   // Taps at prescale/2-1, prescale/2, prescale/2+1.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_tap
         logic [PRESCALE_W-1:0] tap_edge;
         logic                  tap_reg;

         assign tap_edge = half_edge + PRESCALE_W'(gi) - PRESCALE_W'(1);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               tap_reg <= 1'b1;
            end else if (run && (edge_cnt_reg == tap_edge)) begin
               tap_reg <= rx_in;
            end
         end

         assign taps[gi] = tap_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sampled_bit_reg <= 1'b1;
      end else if (run && (edge_cnt_reg == vote_edge)) begin
         sampled_bit_reg <= majority3(taps);
      end
   end

   assign sampled_bit  = sampled_bit_reg;
   assign sample_valid = run && (edge_cnt_reg == last_edge);

endmodule

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// UART receiver: start / DATA_WIDTH data bits LSB first / optional parity /
// stop, oversampled by Prescale clocks per bit.
// Ports:
//   CLK         oversampling clock
//   RST         asynchronous active-low reset
//   RX_IN       serial line, idle high, already synchronised
//   Prescale    oversampling ratio (8, 16, 32), latched at start detect
//   PAR_EN      parity bit present, latched at start detect
//   PAR_TYP     0 even / 1 odd, latched at start detect
//   P_DATA      last good received word
//   data_valid  1-cycle pulse when P_DATA is updated
//   par_err     1-cycle pulse on parity mismatch
//   stp_err     1-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx_core #(
   parameter int DATA_WIDTH = parameters_pkg::DATA_WIDTH,
   parameter int PRESCALE_W = parameters_pkg::PRESCALE_W
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);
   import parameters_pkg::*;

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   rx_state_e             state_reg;
   rx_state_e             state_next;
   logic [BIT_CNT_W-1:0]  bit_cnt_reg;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [PRESCALE_W-1:0] prescale_reg;
   logic                  par_en_reg;
   logic                  par_typ_reg;
   logic                  par_fail_reg;

   logic                  run;
   logic                  sampled_bit;
   logic                  sample_valid;
   logic                  start_detect;
   logic                  shift_en;
   logic                  par_check;
   logic                  frame_end;

   assign run = (state_reg != RX_IDLE) || start_detect;

   uart_rx_data_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .clk          (CLK),
      .rst_n        (RST),
      .run          (run),
      .prescale     (prescale_reg),
      .rx_in        (RX_IN),
      .sampled_bit  (sampled_bit),
      .sample_valid (sample_valid)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg <= RX_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Every non-idle transition happens on the last edge of a bit period.
   always_comb begin
      state_next   = state_reg;
      start_detect = 1'b0;
      shift_en     = 1'b0;
      par_check    = 1'b0;
      frame_end    = 1'b0;
      case (state_reg)
         RX_IDLE: begin
            if (!RX_IN) begin
               start_detect = 1'b1;
               state_next   = RX_START;
            end
         end
         RX_START: begin
            if (sample_valid) begin
               // A start bit that votes high was a glitch: drop it silently.
               state_next = sampled_bit ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (sample_valid) begin
               shift_en = 1'b1;
               if (bit_cnt_reg == LAST_BIT) begin
                  state_next = par_en_reg ? RX_PARITY : RX_STOP;
               end
            end
         end
         RX_PARITY: begin
            if (sample_valid) begin
               par_check  = 1'b1;
               state_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (sample_valid) begin
               frame_end  = 1'b1;
               state_next = RX_IDLE;
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         prescale_reg <= PRESCALE_W'(8);
         par_en_reg   <= 1'b0;
         par_typ_reg  <= 1'b0;
         par_fail_reg <= 1'b0;
         P_DATA       <= '0;
         data_valid   <= 1'b0;
         par_err      <= 1'b0;
         stp_err      <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;

         if (start_detect) begin
            prescale_reg <= Prescale;
            par_en_reg   <= PAR_EN;
            par_typ_reg  <= PAR_TYP;
            par_fail_reg <= 1'b0;
            bit_cnt_reg  <= '0;
         end

         // Line order is LSB first, so each new bit enters at the MSB.
         if (shift_en) begin
            shift_reg   <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + BIT_CNT_W'(1);
         end

         if (par_check) begin
            par_fail_reg <= sampled_bit != (^shift_reg ^ par_typ_reg);
         end

         if (frame_end) begin
            stp_err <= ~sampled_bit;
            par_err <= par_fail_reg;
            if (sampled_bit && !par_fail_reg) begin
               P_DATA     <= shift_reg;
               data_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core. Cycle 0 of a frame is the clock edge that
// first sees the start bit low; output pulses are recorded with the index of
// the clock edge that produced them.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;
   import parameters_pkg::*;

   logic       CLK      = 1'b0;
   logic       RST      = 1'b0;
   logic       RX_IN    = 1'b1;
   logic [5:0] Prescale = 6'd8;
   logic       PAR_EN   = 1'b0;
   logic       PAR_TYP  = 1'b0;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int checks      = 0;
   int errors      = 0;
   int cyc         = 0;
   int frame_start = 0;
   int dv_cnt      = 0;
   int pe_cnt      = 0;
   int se_cnt      = 0;
   int dv_at       = 0;
   int pe_at       = 0;
   int se_at       = 0;
   int first_dv_at = 0;

   uart_rx_core dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
      if (data_valid === 1'b1) begin dv_cnt++; dv_at = cyc; end
      if (par_err === 1'b1)    begin pe_cnt++; pe_at = cyc; end
      if (stp_err === 1'b1)    begin se_cnt++; se_at = cyc; end
   endtask

   task automatic clear_mon();
      dv_cnt = 0;
      pe_cnt = 0;
      se_cnt = 0;
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drives one full frame. Configuration inputs are scrambled after the
   // start bit so a receiver that fails to latch them misdecodes the frame.
   // glitch_bit: line-bit index receiving a 1-cycle inversion at edge ps/2.
   task automatic send_frame(input logic [7:0] data, input logic [5:0] ps,
                             input logic pen, input logic ptyp, input logic pbit,
                             input logic sbit, input int glitch_bit);
      logic line [0:10];
      int   nb;
      int   half;
      half    = int'(ps) / 2;
      line[0] = 1'b0;
      for (int i = 0; i < 8; i++) line[i+1] = data[i];
      nb = 9;
      if (pen) begin
         line[9] = pbit;
         nb      = 10;
      end
      line[nb] = sbit;
      nb++;
      Prescale    = ps;
      PAR_EN      = pen;
      PAR_TYP     = ptyp;
      frame_start = cyc + 1;
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < int'(ps); c++) begin
            RX_IN = line[b] ^ ((b == glitch_bit) && (c == half));
            tick();
         end
         if (b == 0) begin
            Prescale = ps ^ 6'h18;
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
         end
      end
      Prescale = ps;
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
   endtask

   initial begin
      // Reset state
      RST = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("rst_p_data", 32'(P_DATA), 32'h0);
      check("rst_data_valid", 32'(data_valid), 32'h0);
      check("rst_par_err", 32'(par_err), 32'h0);
      check("rst_stp_err", 32'(stp_err), 32'h0);
      check("rst_state", 32'(dut.state_reg), 32'(RX_IDLE));
      RST = 1'b1;
      idle(5);

      // Good frame, P=8, even parity, 0xA5 (four ones -> parity bit 0)
      clear_mon();
      send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      check("t1_valid_cnt", 32'(dv_cnt), 32'd1);
      check("t1_valid_cycle", 32'(dv_at - frame_start), 32'd87);
      check("t1_p_data", 32'(P_DATA), 32'hA5);
      check("t1_par_err_cnt", 32'(pe_cnt), 32'd0);
      check("t1_stp_err_cnt", 32'(se_cnt), 32'd0);

      // Same frame, wrong parity bit
      clear_mon();
      send_frame(8'hA5, 6'd8, 1'b1, 1'b0, 1'b1, 1'b1, -1);
      idle(4);
      check("t2_par_err_cnt", 32'(pe_cnt), 32'd1);
      check("t2_par_err_cycle", 32'(pe_at - frame_start), 32'd87);
      check("t2_valid_cnt", 32'(dv_cnt), 32'd0);
      check("t2_stp_err_cnt", 32'(se_cnt), 32'd0);
      check("t2_p_data_kept", 32'(P_DATA), 32'hA5);

      // No parity, P=16, stop bit low
      clear_mon();
      send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idle(20);
      check("t3_stp_err_cnt", 32'(se_cnt), 32'd1);
      check("t3_stp_err_cycle", 32'(se_at - frame_start), 32'd159);
      check("t3_valid_cnt", 32'(dv_cnt), 32'd0);
      check("t3_par_err_cnt", 32'(pe_cnt), 32'd0);
      check("t3_p_data_kept", 32'(P_DATA), 32'hA5);

      // Back-to-back 0x3C then 0xC3
      clear_mon();
      send_frame(8'h3C, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      check("t4_first_p_data", 32'(P_DATA), 32'h3C);
      check("t4_first_cycle", 32'(dv_at - frame_start), 32'd159);
      first_dv_at = dv_at;
      send_frame(8'hC3, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
      check("t4_valid_cnt", 32'(dv_cnt), 32'd2);
      check("t4_valid_spacing", 32'(dv_at - first_dv_at), 32'd160);
      check("t4_second_p_data", 32'(P_DATA), 32'hC3);
      check("t4_err_cnt", 32'(pe_cnt + se_cnt), 32'd0);

      // Start glitch: low for 3 cycles, P=8
      clear_mon();
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      RX_IN = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("t5_state_edge6", 32'(dut.state_reg), 32'(RX_START));
      tick();
      check("t5_state_edge7", 32'(dut.state_reg), 32'(RX_IDLE));
      idle(10);
      check("t5_pulses", 32'(dv_cnt + pe_cnt + se_cnt), 32'd0);
      check("t5_state_final", 32'(dut.state_reg), 32'(RX_IDLE));

      // Glitch at mid-bit of data bit 2 (line bit 3) of 0x96, P=16
      clear_mon();
      send_frame(8'h96, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      idle(4);
      check("t6_valid_cnt", 32'(dv_cnt), 32'd1);
      check("t6_p_data", 32'(P_DATA), 32'h96);
      check("t6_valid_cycle", 32'(dv_at - frame_start), 32'd159);

      // Reset in the middle of DATA, then a clean 0x5A with odd parity (bit 1)
      clear_mon();
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      RX_IN = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      RX_IN = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("t7_state_before_rst", 32'(dut.state_reg), 32'(RX_DATA));
      #2;
      RST = 1'b0;
      #1;
      check("t7_rst_p_data", 32'(P_DATA), 32'h0);
      check("t7_rst_state", 32'(dut.state_reg), 32'(RX_IDLE));
      RX_IN = 1'b1;
      tick();
      tick();
      RST = 1'b1;
      idle(5);
      send_frame(8'h5A, 6'd8, 1'b1, 1'b1, 1'b1, 1'b1, -1);
      idle(4);
      check("t7_valid_cnt", 32'(dv_cnt), 32'd1);
      check("t7_p_data", 32'(P_DATA), 32'h5A);
      check("t7_valid_cycle", 32'(dv_at - frame_start), 32'd87);
      check("t7_err_cnt", 32'(pe_cnt + se_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout reached before summary");
      $fatal(1, "timeout");
   end

endmodule
